// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module  : stream_mux_rr
// Brief   : N:1 registered valid/ready stream mux with round-robin arbitration.
//           Optional forced-channel select when MUX_FORCE_SEL_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef MUX_FORCE_SEL_EN
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
`endif
    output logic [SEL_W-1:0]          out_sel
);

    localparam logic [SEL_W-1:0] C_LAST = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   C_NCH  = (SEL_W + 1)'(CHANNELS);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;

    logic             w_free;
    logic             w_found;
    logic             w_forced;
    logic [SEL_W-1:0] w_grant;
    logic [SEL_W-1:0] w_next_ptr;
    logic [WIDTH-1:0] w_gdata;

    assign w_free = !r_valid || out_ready;

    // Scan from ptr upward with wrap; the first valid channel wins.
    always_comb begin
        logic [SEL_W:0] idx;
        w_found  = 1'b0;
        w_forced = 1'b0;
        w_grant  = '0;
        idx      = '0;
`ifdef MUX_FORCE_SEL_EN
        if (force_en) begin
            w_forced = 1'b1;
            if ({1'b0, force_sel} < C_NCH) begin
                w_found = in_valid[force_sel];
                w_grant = force_sel;
            end
        end else
`endif
        begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = {1'b0, r_ptr} + (SEL_W + 1)'(k);
                if (idx >= C_NCH) begin
                    idx = idx - C_NCH;
                end
                if (!w_found && in_valid[idx[SEL_W-1:0]]) begin
                    w_found = 1'b1;
                    w_grant = idx[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = rst_n && w_free && w_found && (w_grant == SEL_W'(i));
        end
    end

    assign w_next_ptr = (w_grant == C_LAST) ? '0 : w_grant + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_free) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_data  <= w_gdata;
                r_sel   <= w_grant;
                // A forced grant leaves the round-robin position untouched.
                if (!w_forced) begin
                    r_ptr <= w_next_ptr;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_mux_rr
// Brief   : Randomised and directed bench for stream_mux_rr (4- and 3-channel).
// Revision: 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic           out_ready;

    logic [3:0]     rdy4;
    logic [2:0]     rdy3;
    logic [W-1:0]   od4, od3;
    logic           ov4, ov3;
    logic [1:0]     os4, os3;
`ifdef MUX_FORCE_SEL_EN
    logic           force_en;
    logic [1:0]     force_sel;
`endif

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(W), .CHANNELS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (rdy4),
        .out_data  (od4),
        .out_valid (ov4),
        .out_ready (out_ready),
`ifdef MUX_FORCE_SEL_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .out_sel   (os4)
    );

    stream_mux_rr #(.WIDTH(W), .CHANNELS(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data[3*W-1:0]),
        .in_valid  (in_valid[2:0]),
        .in_ready  (rdy3),
        .out_data  (od3),
        .out_valid (ov3),
        .out_ready (out_ready),
`ifdef MUX_FORCE_SEL_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .out_sel   (os3)
    );

    // Reference model: one entry per instance (0 = 4 channels, 1 = 3 channels).
    int           nch [2];
    bit           mv  [2];
    logic [W-1:0] md  [2];
    int           ms  [2];
    int           mp  [2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_forced();
`ifdef MUX_FORCE_SEL_EN
        return force_en;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int grant_of(input int inst);
        int c;
`ifdef MUX_FORCE_SEL_EN
        if (force_en) begin
            if (int'(force_sel) < nch[inst] && in_valid[force_sel]) return int'(force_sel);
            return -1;
        end
`endif
        for (int k = 0; k < nch[inst]; k++) begin
            c = (mp[inst] + k) % nch[inst];
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic cycle();
        int           g    [2];
        bit           free [2];
        logic [3:0]   er   [2];
        bit           nv   [2];
        logic [W-1:0] nd   [2];
        int           ns   [2];
        int           np   [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            g[i]    = grant_of(i);
            free[i] = !mv[i] || out_ready;
            er[i]   = (rst_n && free[i] && g[i] >= 0) ? (4'b0001 << g[i]) : 4'b0000;
            nv[i] = mv[i]; nd[i] = md[i]; ns[i] = ms[i]; np[i] = mp[i];
            if (!rst_n) begin
                nv[i] = 1'b0; nd[i] = '0; ns[i] = 0; np[i] = 0;
            end else if (free[i]) begin
                if (g[i] >= 0) begin
                    nv[i] = 1'b1;
                    nd[i] = in_data[g[i]*W +: W];
                    ns[i] = g[i];
                    if (!is_forced()) np[i] = (g[i] + 1) % nch[i];
                end else begin
                    nv[i] = 1'b0;
                end
            end
        end
        check("in_ready4", {60'd0, rdy4}, {60'd0, er[0]});
        check("in_ready3", {61'd0, rdy3}, {60'd0, er[1]});
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            mv[i] = nv[i]; md[i] = nd[i]; ms[i] = ns[i]; mp[i] = np[i];
        end
        check("out_valid4", {63'd0, ov4}, {63'd0, mv[0]});
        check("out_data4",  {32'd0, od4}, {32'd0, md[0]});
        check("out_sel4",   {62'd0, os4}, 64'(ms[0]));
        check("out_valid3", {63'd0, ov3}, {63'd0, mv[1]});
        check("out_data3",  {32'd0, od3}, {32'd0, md[1]});
        check("out_sel3",   {62'd0, os3}, 64'(ms[1]));
    endtask

    // Valid may drop at any time; data changes only while a channel is idle.
    task automatic randomize_sources();
        for (int c = 0; c < 4; c++) begin
            if (in_valid[c]) begin
                if ($urandom_range(3) == 0) in_valid[c] = 1'b0;
            end else if ($urandom_range(1) == 1) begin
                in_data[c*W +: W] = $urandom;
                in_valid[c]       = 1'b1;
            end
        end
    endtask

    initial begin
        nch[0] = 4; nch[1] = 3;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0; md[i] = '0; ms[i] = 0; mp[i] = 0;
        end
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        for (int c = 0; c < 4; c++) in_data[c*W +: W] = W'(32'hA0 + c);
`ifdef MUX_FORCE_SEL_EN
        force_en  = 1'b0;
        force_sel = 2'd0;
`endif

        // Reset held with every channel requesting.
        repeat (2) cycle();

        // Round robin, one word per cycle.
        rst_n = 1'b1;
        repeat (5) cycle();

        // Backpressure, then release.
        out_ready = 1'b0;
        repeat (3) cycle();
        out_ready = 1'b1;
        repeat (2) cycle();

        // Wrap and skip: reach ptr=3, then in_valid=0101.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        in_valid = 4'b0101;
        repeat (2) cycle();

        // Reset mid-stream while a word is held.
        in_valid  = 4'hF;
        out_ready = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) cycle();

`ifdef MUX_FORCE_SEL_EN
        force_en  = 1'b1;
        force_sel = 2'd2;
        repeat (5) cycle();
        force_sel = 2'd3;
        repeat (3) cycle();
        force_en  = 1'b0;
`endif

        // Randomised traffic with random backpressure and occasional reset.
        for (int n = 0; n < 400; n++) begin
            randomize_sources();
            out_ready = ($urandom_range(3) != 0);
            rst_n     = ($urandom_range(63) != 0);
`ifdef MUX_FORCE_SEL_EN
            force_en  = ($urandom_range(4) == 0);
            force_sel = 2'($urandom_range(3));
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
